// File: rtl/regfile_writeback_queue.sv
// Writeback queue for the dual-port register file: merges mem and ALU results,
// drains one write per cycle in age order, and forwards in-flight values to decode.
module regfile_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic        rf_write,
    output logic [4:0]  rf_dest_addr,
    output logic [31:0] rf_data,
    input  logic [4:0]  a_addr,
    output logic        a_hit,
    output logic [31:0] a_data,
    input  logic [4:0]  b_addr,
    output logic        b_hit,
    output logic [31:0] b_data,
    output logic        idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_alu;
    logic [CNT_W-1:0] count;
    logic             mem_push;
    logic             alu_push;
    logic             pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Youngest pending value for addr: rf_* register first, then queue head to tail.
    function automatic logic [32:0] lookup(input logic [4:0] addr);
        logic [32:0] r;
        int          idx;
        r = '0;
        if (addr != 5'd0) begin
            if (rf_write && (rf_dest_addr == addr))
                r = {1'b1, rf_data};
            for (int i = 0; i < DEPTH; i++) begin
                idx = int'(head) + i;
                if (idx >= DEPTH)
                    idx = idx - DEPTH;
                if ((i < int'(count)) && (q_rd[idx[PTR_W-1:0]] == addr))
                    r = {1'b1, q_data[idx[PTR_W-1:0]]};
            end
        end
        return r;
    endfunction

    // Thresholds leave room for both sources to transfer in the same cycle.
    assign mem_ready = rst_n && (count <= CNT_W'(DEPTH - 1));
    assign alu_ready = rst_n && (count <= CNT_W'(DEPTH - 2));

    // x0 results complete the handshake but are dropped.
    assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign pop      = (count != '0);
    assign tail_alu = mem_push ? ptr_inc(tail) : tail;
    assign idle     = (count == '0) && !rf_write;

    always_ff @(posedge clk) begin
        if (mem_push) begin
            q_rd[tail]   <= mem_rd;
            q_data[tail] <= mem_data;
        end
        if (alu_push) begin
            q_rd[tail_alu]   <= alu_rd;
            q_data[tail_alu] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            rf_write     <= 1'b0;
            rf_dest_addr <= 5'd0;
            rf_data      <= 32'd0;
        end else begin
            count <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
            tail  <= alu_push ? ptr_inc(tail_alu) : tail_alu;
            if (pop) begin
                head         <= ptr_inc(head);
                rf_write     <= 1'b1;
                rf_dest_addr <= q_rd[head];
                rf_data      <= q_data[head];
            end else begin
                rf_write <= 1'b0;
            end
        end
    end

    always_comb begin
        {a_hit, a_data} = lookup(a_addr);
        {b_hit, b_data} = lookup(b_addr);
    end

endmodule
